// File: rtl/bcd_xs3_pkg.sv
// Shared encodings and constants for the serial BCD <-> excess-3 converter.
// Holds mode/state enums, the serial addend constants and digit-valid bounds.
package bcd_xs3_pkg;

    typedef enum logic {
        MODE_ADD3 = 1'b0,   // BCD -> excess-3
        MODE_SUB3 = 1'b1    // excess-3 -> BCD
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [3:0] K_ADD3  = 4'b0011;
    localparam logic [3:0] K_SUB3  = 4'b1101;  // two's complement of 3

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] XS3_MIN = 4'd3;
    localparam logic [3:0] XS3_MAX = 4'd12;

    function automatic logic [3:0] k_of(input mode_e m);
        return (m == MODE_SUB3) ? K_SUB3 : K_ADD3;
    endfunction

    function automatic logic digit_invalid(input mode_e m, input logic [3:0] d);
        if (m == MODE_ADD3)
            return (d > BCD_MAX);
        else
            return (d < XS3_MIN) || (d > XS3_MAX);
    endfunction

endpackage

// File: rtl/xs3_bit_slice.sv
// Stateless one-bit slice of the serial constant adder.
// Produces sum and carry for one input bit, one constant bit and the running carry.
module xs3_bit_slice (
    input  logic bin,
    input  logic k,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = bin ^ k ^ carry_in;
    assign carry_out = (bin & k) | (bin & carry_in) | (k & carry_in);

endmodule

// File: rtl/bcd_excesso3_serial.sv
// Serial BCD <-> excess-3 converter over frames of NDIG 4-bit digits, LSB first.
// Adds (or subtracts) 3 per digit bit-serially and flags digits outside the valid range.
module bcd_excesso3_serial
    import bcd_xs3_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic mode,
    input  logic bin,
    input  logic bin_valid,
    output logic bout,
    output logic bout_valid,
    output logic digit_done,
    output logic digit_err,
    output logic frame_done,
    output logic frame_err,
    output logic busy
);

    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    state_e        state_q, state_d;
    mode_e         mode_q, mode_d;
    logic [1:0]    bit_q, bit_d;
    logic [CW-1:0] dig_q, dig_d;
    logic          carry_q, carry_d;
    logic [2:0]    sh_q, sh_d;
    logic          bout_q, bout_d;
    logic          bout_valid_q, bout_valid_d;
    logic          digit_done_q, digit_done_d;
    logic          digit_err_q, digit_err_d;
    logic          frame_done_q, frame_done_d;
    logic          frame_err_q, frame_err_d;

    logic [3:0]    k_vec;
    logic          k_bit;
    logic          slice_sum;
    logic          slice_cout;
    logic [3:0]    full_digit;
    logic          dig_invalid;

    assign k_vec = k_of(mode_q);
    assign k_bit = k_vec[bit_q];

    xs3_bit_slice u_slice (
        .bin       (bin),
        .k         (k_bit),
        .carry_in  (carry_q),
        .sum       (slice_sum),
        .carry_out (slice_cout)
    );

    // Bits 0..2 sit in sh_q; the 4th digit bit is the live input.
    assign full_digit  = {bin, sh_q};
    assign dig_invalid = digit_invalid(mode_q, full_digit);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        bit_d        = bit_q;
        dig_d        = dig_q;
        carry_d      = carry_q;
        sh_d         = sh_q;
        bout_d       = 1'b0;
        bout_valid_d = 1'b0;
        digit_done_d = 1'b0;
        digit_err_d  = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = frame_err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    mode_d      = mode_e'(mode);
                    bit_d       = '0;
                    dig_d       = '0;
                    carry_d     = 1'b0;
                    sh_d        = '0;
                    frame_err_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (bin_valid) begin
                    bout_d       = slice_sum;
                    bout_valid_d = 1'b1;
                    sh_d         = {bin, sh_q[2:1]};
                    bit_d        = bit_q + 2'd1;
                    carry_d      = slice_cout;
                    if (bit_q == 2'd3) begin
                        carry_d      = 1'b0;
                        digit_done_d = 1'b1;
                        digit_err_d  = dig_invalid;
                        frame_err_d  = frame_err_q | dig_invalid;
                        dig_d        = dig_q + 1'b1;
                        if (dig_q == LAST_DIG) begin
                            frame_done_d = 1'b1;
                            state_d      = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= MODE_ADD3;
            bit_q        <= '0;
            dig_q        <= '0;
            carry_q      <= 1'b0;
            sh_q         <= '0;
            bout_q       <= 1'b0;
            bout_valid_q <= 1'b0;
            digit_done_q <= 1'b0;
            digit_err_q  <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            bit_q        <= bit_d;
            dig_q        <= dig_d;
            carry_q      <= carry_d;
            sh_q         <= sh_d;
            bout_q       <= bout_d;
            bout_valid_q <= bout_valid_d;
            digit_done_q <= digit_done_d;
            digit_err_q  <= digit_err_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bout       = bout_q;
    assign bout_valid = bout_valid_q;
    assign digit_done = digit_done_q;
    assign digit_err  = digit_err_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q == ST_RUN);

endmodule

// File: doc/bcd_excesso3_serial.md
BCD_EXCESSO3_SERIAL -- requirements
Module: bcd_excesso3_serial

Interface
REQ-001 Parameter NDIG, default 4, number of 4-bit digits per frame; the block SHALL support 1..16.
REQ-002 Parameter CW, default $clog2(NDIG) (minimum 1), digit-counter width; it SHALL be derived, not overridden.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins a frame; sampled only in IDLE.
REQ-006 mode  input  1  conversion mode: 0 = BCD->excess-3 (+3), 1 = excess-3->BCD (-3); latched with start.
REQ-007 bin  input  1  serial data bit, LSB first within each digit, digit 0 first.
REQ-008 bin_valid  input  1  qualifies bin; absence stalls the frame.
REQ-009 bout  output  1  converted serial bit, same bit order as bin.
REQ-010 bout_valid  output  1  qualifies bout.
REQ-011 digit_done  output  1  pulse with the 4th output bit of each digit.
REQ-012 digit_err  output  1  pulse with digit_done when the input digit was invalid.
REQ-013 frame_done  output  1  pulse with digit_done of digit NDIG-1.
REQ-014 frame_err  output  1  sticky OR of digit_err for the current/last frame.
REQ-015 busy  output  1  high while in RUN.

Function
REQ-016 The FSM SHALL have two states: IDLE and RUN.
REQ-017 IDLE->RUN on start; mode SHALL be latched, bit and digit counters and carry cleared, frame_err cleared.
REQ-018 In IDLE, bin_valid SHALL be ignored: no output, no counter change.
REQ-019 A bit SHALL be accepted in RUN on a cycle with bin_valid=1; start and bin_valid in the same IDLE cycle SHALL accept no bit.
REQ-020 For each accepted bit at position i (0..3), bout SHALL be bin XOR K[i] XOR carry, registered, with bout_valid=1 exactly one cycle later (latency 1).
REQ-021 K SHALL be 4'b0011 in mode 0 and 4'b1101 (two's complement of 3) in mode 1; carry SHALL be majority(bin, K[i], carry), cleared at each digit start, and the carry out of bit 3 SHALL be discarded.
REQ-022 The block SHALL assemble each input digit in a 4-bit shift register; on bit 3 the full digit SHALL be {bin, sh[2:0]}.
REQ-023 A digit SHALL be invalid when greater than 9 in mode 0, or less than 3 or greater than 12 in mode 1; invalid digits SHALL still be converted modulo 16.
REQ-024 The bit counter SHALL wrap 3->0 and advance the digit counter; accepting bit 3 of digit NDIG-1 SHALL return the FSM to IDLE.
REQ-025 digit_done, digit_err and frame_done SHALL be registered and coincide with the bout_valid of that digit's 4th bit.
REQ-026 frame_err SHALL be set in the same cycle as any digit_err and held until the next accepted start or reset.
REQ-027 start while in RUN SHALL be ignored; mode changes during RUN SHALL have no effect.
REQ-028 Gaps in bin_valid SHALL hold all state; bout_valid SHALL be low in gap cycles, and bout is don't-care there.
REQ-029 start SHALL be accepted in the cycle in which frame_done is asserted, allowing back-to-back frames.

Reset
REQ-030 On reset, the FSM SHALL go to IDLE, counters, carry and the shift register SHALL clear, and bout, bout_valid, digit_done, digit_err, frame_done, frame_err and busy SHALL all be 0 in the following cycle.
REQ-031 Reset mid-frame SHALL abandon the frame with no frame_done; the next frame SHALL need a new start.

Structure
REQ-032 The shared package bcd_xs3_pkg SHALL hold the mode encodings, K_ADD3 = 4'b0011, K_SUB3 = 4'b1101, the state encodings and the digit-valid bounds (9, 3, 12).
REQ-033 The block SHALL contain one sub-module, xs3_bit_slice, a serial constant-adder slice (bin, k, carry_in -> sum, carry_out) with no state.
REQ-034 The FSM, counters and error logic SHALL remain in bcd_excesso3_serial.

Verification
REQ-035 NDIG=1, mode 0: input 7 as bits 1,1,1,0 -> bout 0,1,0,1 (10) with digit_done and frame_done on the 4th bit and digit_err=0.
REQ-036 NDIG=2, mode 0: digits 9 then 5 (bits 1,0,0,1 then 1,0,1,0) -> outputs 12 then 8, frame_done on digit 1 only, frame_err=0.
REQ-037 mode 1: input 12 (bits 0,0,1,1) -> output 9; input 2 -> digit_err=1, frame_err=1 until the next start.
REQ-038 mode 0: input 11 (bits 1,1,0,1) -> output 14 with digit_err=1; bin_valid gaps of 3 cycles between bits -> identical outputs and bout_valid low during gaps.
REQ-039 Reset asserted after bit 2 of digit 1 -> all outputs 0 next cycle, no frame_done; start, then a full frame -> correct conversion from digit 0.
REQ-040 Back-to-back frames: start in the cycle frame_done is asserted -> second frame converts correctly with latched new mode; start during RUN -> ignored.
